mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared 256x8 memory with a CPU / front-panel debug arbiter and an LED write mirror.
// Define MEMARB_RR_EN for round-robin arbitration; the default build uses fixed CPU priority.
module mem_port_arbiter #(
  parameter int              AW       = 8,
  parameter int              DW       = 8,
  parameter logic [AW-1:0]   LED_ADDR = 8'hFF
) (
  input  logic          CLK_12MHz,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [DW-1:0] led,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  logic [1:0]    state_reg, state_next;
  logic          owner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] led_reg;
  logic [DW-1:0] mem_q;

  logic          any_req;
  logic          win_dbg;
  logic          take_req;
  logic          commit;
  logic          read_cycle;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [1:0]    gnt_vec;
  logic [1:0]    rvalid_vec;
  logic [DW-1:0] rdata_vec      [2];
  logic [DW-1:0] rdata_hold_reg [2];

  assign any_req    = cpu_req | dbg_req;
  assign take_req   = (state_reg == IDLE) && any_req;
  assign commit     = (state_reg == ACCESS) && we_reg;
  assign read_cycle = (state_reg == ACCESS) && !we_reg;

`ifdef MEMARB_RR_EN
  // Pointer remembers who won last; reset value DBG lets the CPU take the first tie.
  logic last_dbg_reg;

  always_ff @(posedge CLK_12MHz) begin
    if (!rst_n) begin
      last_dbg_reg <= PORT_DBG;
    end else if (take_req) begin
      last_dbg_reg <= win_dbg;
    end
  end

  assign win_dbg = dbg_req & (~cpu_req | ~last_dbg_reg);
`else
  assign win_dbg = dbg_req & ~cpu_req;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_12MHz) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= PORT_CPU;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      led_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (take_req) begin
        owner_reg <= win_dbg;
        we_reg    <= win_dbg ? dbg_we    : cpu_we;
        addr_reg  <= win_dbg ? dbg_addr  : cpu_addr;
        wdata_reg <= win_dbg ? dbg_wdata : cpu_wdata;
      end
      if (commit && (addr_reg == LED_ADDR)) begin
        led_reg <= wdata_reg;
      end
    end
  end

  // The array itself has no reset; rst_n only blocks a write caught by reset mid-access.
  always_ff @(posedge CLK_12MHz) begin
    if (rst_n && commit) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge CLK_12MHz) begin
    if (read_cycle) begin
      mem_q <= mem[addr_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic port_is_owner;

      assign port_is_owner  = (owner_reg == ((gi == 1) ? PORT_DBG : PORT_CPU));
      assign gnt_vec[gi]    = (state_reg == ACCESS) && port_is_owner;
      assign rvalid_vec[gi] = (state_reg == RESP) && !we_reg && port_is_owner;

      // Read data shows the fresh array word during RESP and the last value afterwards.
      always_ff @(posedge CLK_12MHz) begin
        if (!rst_n) begin
          rdata_hold_reg[gi] <= '0;
        end else if (rvalid_vec[gi]) begin
          rdata_hold_reg[gi] <= mem_q;
        end
      end

      assign rdata_vec[gi] = rvalid_vec[gi] ? mem_q : rdata_hold_reg[gi];
    end
  endgenerate

  assign cpu_gnt    = gnt_vec[0];
  assign cpu_rvalid = rvalid_vec[0];
  assign cpu_rdata  = rdata_vec[0];
  assign dbg_gnt    = gnt_vec[1];
  assign dbg_rvalid = rvalid_vec[1];
  assign dbg_rdata  = rdata_vec[1];
  assign led        = led_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: access timing, LED mirror, arbitration and reset cases.
module tb_mem_port_arbiter;

  logic       CLK_12MHz = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic [7:0] led;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_dbg_win;

  always #5 CLK_12MHz = ~CLK_12MHz;

  mem_port_arbiter dut (
    .CLK_12MHz (CLK_12MHz),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .led       (led),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge CLK_12MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access from an IDLE start; returns in the next IDLE cycle.
  task automatic do_access(input string tag, input bit dbg, input bit we,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rd);
    if (dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    tick;
    chk({tag, "_gnt"},       dbg ? dbg_gnt : cpu_gnt, 8'd1);
    chk({tag, "_other_gnt"}, dbg ? cpu_gnt : dbg_gnt, 8'd0);
    chk({tag, "_busy_acc"},  busy, 8'd1);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick;
    chk({tag, "_rvalid"},       dbg ? dbg_rvalid : cpu_rvalid, we ? 8'd0 : 8'd1);
    chk({tag, "_other_rvalid"}, dbg ? cpu_rvalid : dbg_rvalid, 8'd0);
    if (!we) chk({tag, "_rdata"}, dbg ? dbg_rdata : cpu_rdata, exp_rd);
    tick;
    chk({tag, "_busy_idle"}, busy, 8'd0);
  endtask

  initial begin
`ifdef MEMARB_RR_EN
    exp_dbg_win = 4'b1010;
`else
    exp_dbg_win = 4'b0000;
`endif
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    tick;
    tick;
    chk("rst_busy",       busy,       8'd0);
    chk("rst_cpu_gnt",    cpu_gnt,    8'd0);
    chk("rst_dbg_gnt",    dbg_gnt,    8'd0);
    chk("rst_cpu_rvalid", cpu_rvalid, 8'd0);
    chk("rst_dbg_rvalid", dbg_rvalid, 8'd0);
    chk("rst_cpu_rdata",  cpu_rdata,  8'h00);
    chk("rst_dbg_rdata",  dbg_rdata,  8'h00);
    chk("rst_led",        led,        8'h00);
    rst_n = 1'b1;
    tick;

    do_access("cpu_wr_10", 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
    do_access("cpu_rd_10", 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
    chk("cpu_rdata_hold", cpu_rdata, 8'hA5);

    do_access("dbg_wr_ff", 1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00);
    chk("led_mirror", led, 8'h3C);
    do_access("cpu_rd_ff", 1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C);
    do_access("dbg_rd_10", 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Both ports ask for a read in each of four consecutive arbitrations.
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'hFF;
      tick;
      chk($sformatf("arb%0d_cpu_gnt", i), cpu_gnt, {7'd0, ~exp_dbg_win[i]});
      chk($sformatf("arb%0d_dbg_gnt", i), dbg_gnt, {7'd0, exp_dbg_win[i]});
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      tick;
      chk($sformatf("arb%0d_cpu_rvalid", i), cpu_rvalid, {7'd0, ~exp_dbg_win[i]});
      chk($sformatf("arb%0d_dbg_rvalid", i), dbg_rvalid, {7'd0, exp_dbg_win[i]});
      chk($sformatf("arb%0d_rdata", i), exp_dbg_win[i] ? dbg_rdata : cpu_rdata,
          exp_dbg_win[i] ? 8'h3C : 8'hA5);
      tick;
    end

    // A debug request that exists only during RESP must be ignored.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick;
    cpu_req = 1'b0;
    tick;
    chk("pulse_cpu_rvalid", cpu_rvalid, 8'd1);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
    tick;
    dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pulse_dbg_gnt%0d", i), dbg_gnt, 8'd0);
      chk($sformatf("pulse_busy%0d", i), busy, 8'd0);
      tick;
    end

    // Reset while a read is in RESP.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick;
    cpu_req = 1'b0;
    tick;
    chk("rresp_rvalid_before", cpu_rvalid, 8'd1);
    rst_n = 1'b0;
    tick;
    chk("rresp_rvalid_after", cpu_rvalid, 8'd0);
    chk("rresp_rdata_after",  cpu_rdata,  8'h00);
    chk("rresp_busy_after",   busy,       8'd0);
    rst_n = 1'b1;
    tick;

    // Reset at the closing edge of a write's ACCESS cycle.
    do_access("cpu_wr_20_pre", 1'b0, 1'b1, 8'h20, 8'h00, 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
    tick;
    chk("racc_gnt", cpu_gnt, 8'd1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    tick;
    chk("racc_busy",   busy,       8'd0);
    chk("racc_gnt_lo", cpu_gnt,    8'd0);
    chk("racc_rvalid", cpu_rvalid, 8'd0);
    rst_n = 1'b1;
    tick;
    chk("racc_rvalid_post", cpu_rvalid, 8'd0);
    chk("racc_busy_post",   busy,       8'd0);
    do_access("dbg_rd_20", 1'b1, 1'b0, 8'h20, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
